pcie_tl_vc_scheduler: RTL and testbench

PCIE_TL_VC_SCHEDULER -- requirements
Module: pcie_tl_vc_scheduler

---
 rtl/PCIe_PKG.sv | 4 +
 rtl/pcie_tl_vc_scheduler.sv | 113 +++++++++++
 tb/tb_pcie_tl_vc_scheduler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/PCIe_PKG.sv
// Shared PCIe transaction-layer constants.
package PCIe_PKG;
  localparam int PCIe_TL_TLP_PACKET_SIZE = 128;
endpackage

// File: rtl/pcie_tl_vc_scheduler.sv
// Two-VC weighted round-robin TLP scheduler with per-VC credit tracking and a
// single registered output stage towards the data link layer.
module pcie_tl_vc_scheduler #(
  parameter int TLP_W    = PCIe_PKG::PCIe_TL_TLP_PACKET_SIZE,
  parameter int W_VC0    = 1,
  parameter int W_VC1    = 3,
  parameter int CRD_W    = 8,
  parameter int INIT_CRD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fc_valid_i,
  input  logic             vc0_empty_i,
  input  logic             vc1_empty_i,
  input  logic [TLP_W-1:0] vc0_rdata_i,
  input  logic [TLP_W-1:0] vc1_rdata_i,
  output logic             vc0_rden_o,
  output logic             vc1_rden_o,
  input  logic             crd_ret_vc0_i,
  input  logic             crd_ret_vc1_i,
  output logic             tlp_valid_o,
  output logic [TLP_W-1:0] tlp_o,
  output logic             tlp_vc_o,
  input  logic             tlp_ready_i,
  output logic [CRD_W-1:0] crd_vc0_o,
  output logic [CRD_W-1:0] crd_vc1_o
);

  localparam int W_MAX = (W_VC0 > W_VC1) ? W_VC0 : W_VC1;
  localparam int CNT_W = $clog2(W_MAX + 1);
  localparam logic [CNT_W-1:0] W0_C   = CNT_W'(W_VC0);
  localparam logic [CNT_W-1:0] W1_C   = CNT_W'(W_VC1);
  localparam logic [CNT_W-1:0] WMAX_C = CNT_W'(W_MAX);
  localparam logic [CRD_W-1:0] INIT_C = CRD_W'(INIT_CRD);

  // crd - grant + ret with the increment clamped at all-ones; grants never
  // reach a zero counter, so the extra bit only ever signals overflow.
  function automatic logic [CRD_W-1:0] crd_next(input logic [CRD_W-1:0] crd,
                                                input logic grant,
                                                input logic ret);
    logic [CRD_W:0] sum;
    sum = {1'b0, crd} + {{CRD_W{1'b0}}, ret} - {{CRD_W{1'b0}}, grant};
    crd_next = sum[CRD_W] ? {CRD_W{1'b1}} : sum[CRD_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    cnt_inc = (cnt == WMAX_C) ? cnt : cnt + CNT_W'(1);
  endfunction

  logic             cur_vc;
  logic [CNT_W-1:0] grant_cnt;
  logic             free_p0;
  logic             elig0_p0;
  logic             elig1_p0;
  logic             cur_elig_p0;
  logic             oth_elig_p0;
  logic [CNT_W-1:0] w_cur_p0;
  logic             grant_p0;
  logic             sel_vc_p0;

  // Stage p0: eligibility and arbitration, pops issued in the grant cycle
  always_comb begin
    free_p0     = !tlp_valid_o || tlp_ready_i;
    elig0_p0    = !vc0_empty_i && (crd_vc0_o != '0) && fc_valid_i;
    elig1_p0    = !vc1_empty_i && (crd_vc1_o != '0) && fc_valid_i;
    cur_elig_p0 = cur_vc ? elig1_p0 : elig0_p0;
    oth_elig_p0 = cur_vc ? elig0_p0 : elig1_p0;
    w_cur_p0    = cur_vc ? W1_C : W0_C;
    grant_p0    = 1'b0;
    sel_vc_p0   = cur_vc;
    // Gating on rst_n keeps the FIFOs untouched while reset is held.
    if (free_p0 && rst_n) begin
      if (cur_elig_p0 && ((grant_cnt < w_cur_p0) || !oth_elig_p0)) begin
        grant_p0 = 1'b1;
      end else if (oth_elig_p0) begin
        grant_p0  = 1'b1;
        sel_vc_p0 = !cur_vc;
      end
    end
    vc0_rden_o = grant_p0 && !sel_vc_p0;
    vc1_rden_o = grant_p0 && sel_vc_p0;
  end

  // Stage p1: output register, arbiter state and credit counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlp_valid_o <= 1'b0;
      tlp_o       <= '0;
      tlp_vc_o    <= 1'b0;
      cur_vc      <= 1'b1;
      grant_cnt   <= '0;
      crd_vc0_o   <= INIT_C;
      crd_vc1_o   <= INIT_C;
    end else begin
      crd_vc0_o <= crd_next(crd_vc0_o, vc0_rden_o, crd_ret_vc0_i);
      crd_vc1_o <= crd_next(crd_vc1_o, vc1_rden_o, crd_ret_vc1_i);
      if (grant_p0) begin
        tlp_valid_o <= 1'b1;
        tlp_o       <= sel_vc_p0 ? vc1_rdata_i : vc0_rdata_i;
        tlp_vc_o    <= sel_vc_p0;
        if (sel_vc_p0 == cur_vc) begin
          grant_cnt <= cnt_inc(grant_cnt);
        end else begin
          cur_vc    <= sel_vc_p0;
          grant_cnt <= CNT_W'(1);
        end
      end else if (tlp_ready_i) begin
        tlp_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcie_tl_vc_scheduler.sv
// Directed bench for pcie_tl_vc_scheduler: reset-state vector table plus
// multi-cycle sequences for weighting, credits, stalls and reset.
module tb_pcie_tl_vc_scheduler;
  localparam int TW = PCIe_PKG::PCIe_TL_TLP_PACKET_SIZE;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fc_valid, vc0_empty, vc1_empty;
  logic [TW-1:0] vc0_rdata, vc1_rdata;
  logic          vc0_rden, vc1_rden;
  logic          crd_ret_vc0, crd_ret_vc1;
  logic          tlp_valid;
  logic [TW-1:0] tlp;
  logic          tlp_vc;
  logic          tlp_ready;
  logic [7:0]    crd_vc0, crd_vc1;

  int checks = 0;
  int errors = 0;

  pcie_tl_vc_scheduler #(.W_VC0(1), .W_VC1(3), .CRD_W(8), .INIT_CRD(4)) dut (
    .clk(clk), .rst_n(rst_n), .fc_valid_i(fc_valid),
    .vc0_empty_i(vc0_empty), .vc1_empty_i(vc1_empty),
    .vc0_rdata_i(vc0_rdata), .vc1_rdata_i(vc1_rdata),
    .vc0_rden_o(vc0_rden), .vc1_rden_o(vc1_rden),
    .crd_ret_vc0_i(crd_ret_vc0), .crd_ret_vc1_i(crd_ret_vc1),
    .tlp_valid_o(tlp_valid), .tlp_o(tlp), .tlp_vc_o(tlp_vc),
    .tlp_ready_i(tlp_ready), .crd_vc0_o(crd_vc0), .crd_vc1_o(crd_vc1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves inputs idle and rst_n released right at a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    fc_valid = 1'b1; vc0_empty = 1'b1; vc1_empty = 1'b1;
    crd_ret_vc0 = 1'b0; crd_ret_vc1 = 1'b0; tlp_ready = 1'b1;
    vc0_rdata = '0; vc1_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic fc, e0, e1;
    logic r0, r1;
  } vec_t;

  vec_t tbl[6];
  logic ord[8];
  int   pops;

  initial begin
    tbl[0] = '{fc: 1, e0: 0, e1: 0, r0: 0, r1: 1};
    tbl[1] = '{fc: 1, e0: 0, e1: 1, r0: 1, r1: 0};
    tbl[2] = '{fc: 1, e0: 1, e1: 0, r0: 0, r1: 1};
    tbl[3] = '{fc: 1, e0: 1, e1: 1, r0: 0, r1: 0};
    tbl[4] = '{fc: 0, e0: 0, e1: 0, r0: 0, r1: 0};
    tbl[5] = '{fc: 0, e0: 0, e1: 1, r0: 0, r1: 0};
    ord = '{1, 1, 1, 0, 1, 1, 1, 0};

    // Reset state while held
    rst_n = 1'b0;
    fc_valid = 1'b1; vc0_empty = 1'b0; vc1_empty = 1'b0;
    crd_ret_vc0 = 1'b0; crd_ret_vc1 = 1'b0; tlp_ready = 1'b1;
    vc0_rdata = 'h11; vc1_rdata = 'h22;
    repeat (2) @(negedge clk);
    chk("rst_valid", tlp_valid, 0);
    chk("rst_tlp", tlp, 0);
    chk("rst_vc", tlp_vc, 0);
    chk("rst_rden0", vc0_rden, 0);
    chk("rst_rden1", vc1_rden, 0);
    chk("rst_crd0", crd_vc0, 4);
    chk("rst_crd1", crd_vc1, 4);

    // Table: first decision out of reset (cur_vc=1, grant_cnt=0)
    for (int i = 0; i < 6; i++) begin
      do_reset();
      fc_valid = tbl[i].fc; vc0_empty = tbl[i].e0; vc1_empty = tbl[i].e1;
      vc0_rdata = TW'(32'hA000 + i); vc1_rdata = TW'(32'hB000 + i);
      #1;
      chk($sformatf("tbl%0d_rden0", i), vc0_rden, tbl[i].r0);
      chk($sformatf("tbl%0d_rden1", i), vc1_rden, tbl[i].r1);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), tlp_valid, tbl[i].r0 | tbl[i].r1);
      chk($sformatf("tbl%0d_tlp", i), tlp,
          tbl[i].r1 ? TW'(32'hB000 + i) : (tbl[i].r0 ? TW'(32'hA000 + i) : '0));
      chk($sformatf("tbl%0d_vc", i), tlp_vc, tbl[i].r1);
    end

    // Weighted order 3:1 with credits held steady by returns
    do_reset();
    vc0_empty = 1'b0; vc1_empty = 1'b0; crd_ret_vc0 = 1'b1; crd_ret_vc1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("ord%0d_rden1", i), vc1_rden, ord[i]);
      chk($sformatf("ord%0d_rden0", i), vc0_rden, !ord[i]);
      if (i > 0) begin
        chk($sformatf("ord%0d_outvc", i), tlp_vc, ord[i-1]);
        chk($sformatf("ord%0d_valid", i), tlp_valid, 1);
      end
      @(negedge clk);
    end

    // Credit exhaustion on VC0 and single-credit return
    do_reset();
    vc0_empty = 1'b0;
    pops = 0;
    repeat (8) begin
      #1; if (vc0_rden) pops++;
      @(negedge clk);
    end
    chk("exh_pops", TW'(pops), 4);
    chk("exh_crd0", crd_vc0, 0);
    chk("exh_valid", tlp_valid, 0);
    crd_ret_vc0 = 1'b1;
    #1; chk("exh_ret_nopop", vc0_rden, 0);
    @(negedge clk);
    crd_ret_vc0 = 1'b0;
    chk("exh_crd0_ret", crd_vc0, 1);
    pops = 0;
    repeat (5) begin
      #1; if (vc0_rden) pops++;
      @(negedge clk);
    end
    chk("exh_pops_after", TW'(pops), 1);
    chk("exh_crd0_end", crd_vc0, 0);

    // Back-pressure: output held, no pops, pop again as soon as ready returns
    do_reset();
    vc0_empty = 1'b0; tlp_ready = 1'b0; vc0_rdata = 'hCAFE;
    #1; chk("stall_first_pop", vc0_rden, 1);
    @(negedge clk);
    vc0_rdata = 'hBEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d_rden", i), vc0_rden, 0);
      chk($sformatf("stall%0d_tlp", i), tlp, 'hCAFE);
      chk($sformatf("stall%0d_valid", i), tlp_valid, 1);
      @(negedge clk);
    end
    tlp_ready = 1'b1;
    #1; chk("stall_release_pop", vc0_rden, 1);
    @(negedge clk);
    chk("stall_next_tlp", tlp, 'hBEEF);
    chk("stall_next_valid", tlp_valid, 1);

    // Simultaneous grant and return, then saturation at 255
    do_reset();
    vc1_empty = 1'b0;
    @(negedge clk);
    chk("crd1_after_grant", crd_vc1, 3);
    crd_ret_vc1 = 1'b1;
    #1; chk("crd1_grant_with_ret", vc1_rden, 1);
    @(negedge clk);
    chk("crd1_grant_ret", crd_vc1, 3);
    vc1_empty = 1'b1;
    repeat (252) @(negedge clk);
    chk("crd1_reach_255", crd_vc1, 255);
    @(negedge clk);
    chk("crd1_sat_ret", crd_vc1, 255);
    vc1_empty = 1'b0;
    #1; chk("crd1_sat_grant", vc1_rden, 1);
    @(negedge clk);
    chk("crd1_sat_grant_ret", crd_vc1, 255);
    crd_ret_vc1 = 1'b0;
    @(negedge clk);
    chk("crd1_dec_from_255", crd_vc1, 254);

    // Flow control not yet initialised
    do_reset();
    fc_valid = 1'b0; vc0_empty = 1'b0; vc1_empty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("fc%0d_rden", i), TW'({vc1_rden, vc0_rden}), 0);
      chk($sformatf("fc%0d_valid", i), tlp_valid, 0);
      @(negedge clk);
    end
    fc_valid = 1'b1;
    #1;
    chk("fc_on_rden1", vc1_rden, 1);
    chk("fc_on_rden0", vc0_rden, 0);
    @(negedge clk);
    chk("fc_on_vc", tlp_vc, 1);

    // Reset while a TLP is held
    do_reset();
    vc0_empty = 1'b0; tlp_ready = 1'b0; vc0_rdata = 'h55;
    @(negedge clk);
    chk("midrst_held", tlp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", tlp_valid, 0);
    chk("midrst_tlp", tlp, 0);
    chk("midrst_crd0", crd_vc0, 4);
    chk("midrst_rden0", vc0_rden, 0);
    @(negedge clk);
    chk("midrst_hold_rden0", vc0_rden, 0);
    rst_n = 1'b1; tlp_ready = 1'b1;
    #1; chk("postrst_pop", vc0_rden, 1);
    @(negedge clk);
    chk("postrst_valid", tlp_valid, 1);
    chk("postrst_tlp", tlp, 'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
